// File: rtl/bfs_pkg.sv
// rtl/bfs_pkg.sv - shared encodings for the sink-detection engine
package bfs_pkg;

  localparam logic [1:0] CELL_WATER = 2'b00;
  localparam logic [1:0] CELL_BOAT  = 2'b01;
  localparam logic [1:0] CELL_HIT   = 2'b10;
  localparam logic [1:0] CELL_MISS  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_START = 3'd1,
    ST_WR_START = 3'd2,
    ST_POP      = 3'd3,
    ST_NB_REQ   = 3'd4,
    ST_NB_WAIT  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    DIR_PX = 2'd0,
    DIR_NX = 2'd1,
    DIR_PY = 2'd2,
    DIR_NY = 2'd3
  } dir_t;

endpackage

// File: rtl/bfs_queue.sv
// rtl/bfs_queue.sv - FIFO of {x,y} cells awaiting neighbour expansion
module bfs_queue #(
  parameter int WIDTH = 6,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [CW-1:0] push_x,
  input  logic [CW-1:0] push_y,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic          empty
);
  localparam int D  = WIDTH * WIDTH;
  localparam int PW = $clog2(D);

  logic [2*CW-1:0] slots [D];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign head_x = slots[rd_ptr][2*CW-1:CW];
  assign head_y = slots[rd_ptr][CW-1:0];

  always_ff @(posedge clk) begin
    if (push && !clear) slots[wr_ptr] <= {push_x, push_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bfs.sv
// rtl/bfs.sv - marks a shot cell hit and flood-fills its boat to decide sunk
module bfs #(
  parameter  int WIDTH = 6,
  localparam int CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          bfs_start,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  output logic [CW-1:0] mem_addr_x,
  output logic [CW-1:0] mem_addr_y,
  output logic [1:0]    mem_wr_data,
  input  logic [1:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic          mem_in_valid,
  input  logic          mem_ready,
  output logic          bfs_sink,
  output logic          bfs_done
);
  import bfs_pkg::*;

  localparam int D  = WIDTH * WIDTH;
  localparam int IW = $clog2(D);

  state_t        state;
  dir_t          dir;
  logic [CW-1:0] sx, sy, hx, hy, nx, ny;
  logic [D-1:0]  visited;
  logic          resp;
  logic          q_clear, q_push, q_pop, q_empty;
  logic [CW-1:0] q_px, q_py, q_hx, q_hy;
  logic [CW:0]   cand_x, cand_y;
  logic          cand_ok;

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    return IW'(int'(cy) * WIDTH + int'(cx));
  endfunction

  // A response only counts once the request strobe has been retired.
  assign resp     = mem_ready && !mem_in_valid;
  assign bfs_done = (state == ST_DONE);

  always_comb begin
    cand_x = {1'b0, hx};
    cand_y = {1'b0, hy};
    unique case (dir)
      DIR_PX:  cand_x = {1'b0, hx} + 1'b1;
      DIR_NX:  cand_x = {1'b0, hx} - 1'b1;
      DIR_PY:  cand_y = {1'b0, hy} + 1'b1;
      default: cand_y = {1'b0, hy} - 1'b1;
    endcase
    cand_ok = (cand_x < (CW+1)'(WIDTH)) && (cand_y < (CW+1)'(WIDTH))
              && !visited[cell_idx(cand_x[CW-1:0], cand_y[CW-1:0])];
  end

  always_comb begin
    q_clear = (state == ST_IDLE) && bfs_start;
    q_pop   = (state == ST_POP) && !q_empty;
    q_push  = 1'b0;
    q_px    = sx;
    q_py    = sy;
    if (resp) begin
      if (state == ST_RD_START && mem_rd_data == CELL_HIT) q_push = 1'b1;
      if (state == ST_WR_START) q_push = 1'b1;
      if (state == ST_NB_WAIT && mem_rd_data == CELL_HIT) begin
        q_push = 1'b1;
        q_px   = nx;
        q_py   = ny;
      end
    end
  end

  bfs_queue #(.WIDTH(WIDTH), .CW(CW)) u_queue (
    .clk    (clk),
    .rst    (rstn),
    .clear  (q_clear),
    .push   (q_push),
    .pop    (q_pop),
    .push_x (q_px),
    .push_y (q_py),
    .head_x (q_hx),
    .head_y (q_hy),
    .empty  (q_empty)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state        <= ST_IDLE;
      dir          <= DIR_PX;
      {sx, sy, hx, hy, nx, ny} <= '0;
      visited      <= '0;
      mem_addr_x   <= '0;
      mem_addr_y   <= '0;
      mem_wr_data  <= CELL_WATER;
      mem_wr_en    <= 1'b0;
      mem_in_valid <= 1'b0;
      bfs_sink     <= 1'b0;
    end else begin
      mem_in_valid <= 1'b0;
      unique case (state)
        ST_IDLE: if (bfs_start) begin
          sx           <= x;
          sy           <= y;
          visited      <= '0;
          bfs_sink     <= 1'b0;
          mem_addr_x   <= x;
          mem_addr_y   <= y;
          mem_wr_en    <= 1'b0;
          mem_in_valid <= 1'b1;
          state        <= ST_RD_START;
        end
        ST_RD_START: if (resp) begin
          if (mem_rd_data == CELL_BOAT) begin
            mem_wr_en    <= 1'b1;
            mem_wr_data  <= CELL_HIT;
            mem_in_valid <= 1'b1;
            state        <= ST_WR_START;
          end else if (mem_rd_data == CELL_HIT) begin
            visited[cell_idx(sx, sy)] <= 1'b1;
            state <= ST_POP;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_WR_START: if (resp) begin
          mem_wr_en <= 1'b0;
          visited[cell_idx(sx, sy)] <= 1'b1;
          state <= ST_POP;
        end
        ST_POP: begin
          if (q_empty) begin
            bfs_sink <= 1'b1;
            state    <= ST_DONE;
          end else begin
            hx    <= q_hx;
            hy    <= q_hy;
            dir   <= DIR_PX;
            state <= ST_NB_REQ;
          end
        end
        ST_NB_REQ: begin
          if (cand_ok) begin
            nx           <= cand_x[CW-1:0];
            ny           <= cand_y[CW-1:0];
            mem_addr_x   <= cand_x[CW-1:0];
            mem_addr_y   <= cand_y[CW-1:0];
            mem_wr_en    <= 1'b0;
            mem_in_valid <= 1'b1;
            state        <= ST_NB_WAIT;
          end else if (dir == DIR_NY) begin
            state <= ST_POP;
          end else begin
            dir <= dir_t'(dir + 2'd1);
          end
        end
        ST_NB_WAIT: if (resp) begin
          if (mem_rd_data == CELL_BOAT) begin
            state <= ST_DONE;
          end else begin
            visited[cell_idx(nx, ny)] <= 1'b1;
            if (dir == DIR_NY) begin
              state <= ST_POP;
            end else begin
              dir   <= dir_t'(dir + 2'd1);
              state <= ST_NB_REQ;
            end
          end
        end
        ST_DONE: if (!bfs_start) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfs.sv
// tb/tb_bfs.sv - randomized and directed checks of bfs against a flood-fill model
module tb_bfs;

  localparam int W = 6;

  logic       clk;
  logic       rstn;
  logic       bfs_start;
  logic [2:0] x, y;
  logic [2:0] mem_addr_x, mem_addr_y;
  logic [1:0] mem_wr_data;
  logic [1:0] mem_rd_data;
  logic       mem_wr_en;
  logic       mem_in_valid;
  logic       mem_ready;
  logic       bfs_sink;
  logic       bfs_done;

  int         total = 0;
  int         bad = 0;
  logic [1:0] mem [W*W];
  int         wr_count = 0;
  int         lat = 1;

  bfs #(.WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bfs_start    (bfs_start),
    .x            (x),
    .y            (y),
    .mem_addr_x   (mem_addr_x),
    .mem_addr_y   (mem_addr_y),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_in_valid (mem_in_valid),
    .mem_ready    (mem_ready),
    .bfs_sink     (bfs_sink),
    .bfs_done     (bfs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Boat is sunk iff every boat cell 4-connected to the shot is hit.
  function automatic bit model_sink(input logic [1:0] b [W*W], input int sx, input int sy);
    int qx[$];
    int qy[$];
    bit seen [W*W];
    int cx, cy, px, py;
    int dx[4] = '{1, -1, 0, 0};
    int dy[4] = '{0, 0, 1, -1};
    if (b[sy*W+sx] != 2'b01 && b[sy*W+sx] != 2'b10) return 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    qx.push_back(sx); qy.push_back(sy); seen[sy*W+sx] = 1'b1;
    while (qx.size() > 0) begin
      cx = qx.pop_front(); cy = qy.pop_front();
      if (b[cy*W+cx] == 2'b01) return 1'b0;
      for (int d = 0; d < 4; d++) begin
        px = cx + dx[d]; py = cy + dy[d];
        if (px >= 0 && px < W && py >= 0 && py < W && !seen[py*W+px]
            && (b[py*W+px] == 2'b01 || b[py*W+px] == 2'b10)) begin
          seen[py*W+px] = 1'b1;
          qx.push_back(px); qy.push_back(py);
        end
      end
    end
    return 1'b1;
  endfunction

  // Memory responder: fixed latency, one outstanding request.
  initial begin
    int pend;
    int a;
    logic [1:0] pend_data;
    logic busy, in_rng;
    pend = 0;
    pend_data = 2'b00;
    mem_ready = 1'b0;
    mem_rd_data = 2'b00;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rstn) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mem_ready = 1'b1;
            mem_rd_data = pend_data;
          end
        end
        if (mem_in_valid) begin
          busy = (pend > 0) || mem_ready;
          chk("no_overlap", busy, 0);
          in_rng = (mem_addr_x < W) && (mem_addr_y < W);
          chk("addr_range", in_rng, 1);
          if (in_rng) begin
            a = int'(mem_addr_y) * W + int'(mem_addr_x);
            pend_data = mem[a];
            if (mem_wr_en) begin
              mem[a] = mem_wr_data;
              wr_count++;
            end
          end
          pend = lat;
        end
      end
    end
  end

  task automatic clear_board();
    foreach (mem[i]) mem[i] = 2'b00;
  endtask

  task automatic run_shot(input int sx, input int sy, input string tag);
    logic [1:0] ref_b [W*W];
    bit exp_sink;
    int exp_wr, wr0, diff, cyc;
    ref_b = mem;
    exp_wr = (ref_b[sy*W+sx] == 2'b01) ? 1 : 0;
    if (exp_wr == 1) ref_b[sy*W+sx] = 2'b10;
    exp_sink = model_sink(ref_b, sx, sy);
    wr0 = wr_count;
    @(negedge clk);
    x = 3'(sx); y = 3'(sy); bfs_start = 1'b1;
    @(negedge clk);
    x = 3'($urandom); y = 3'($urandom);
    cyc = 0;
    while (!bfs_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, bfs_done, 1);
    chk({tag, "_sink"}, bfs_sink, exp_sink);
    chk({tag, "_writes"}, wr_count - wr0, exp_wr);
    diff = 0;
    foreach (mem[i]) if (mem[i] !== ref_b[i]) diff++;
    chk({tag, "_board"}, diff, 0);
    bfs_start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_drop"}, bfs_done, 0);
    chk({tag, "_sink_hold"}, bfs_sink, exp_sink);
  endtask

  task automatic directed();
    clear_board();
    mem[1*W+1] = 2'b01; mem[1*W+2] = 2'b01; mem[2*W+1] = 2'b01;
    run_shot(1, 1, "boat3_a");
    chk("mem7_hit", mem[7], 2'b10);
    run_shot(2, 1, "boat3_b");
    run_shot(1, 2, "boat3_c");

    clear_board();
    mem[14] = 2'b01;
    run_shot(2, 2, "isolated");
    chk("mem14_hit", mem[14], 2'b10);

    clear_board();
    run_shot(0, 0, "water");

    clear_board();
    mem[3*W+2] = 2'b01; mem[3*W+3] = 2'b01;
    @(negedge clk);
    x = 3'd2; y = 3'd3; bfs_start = 1'b1;
    #6 rstn = 1'b1;
    #1 chk("rst_async_outs", {mem_in_valid, bfs_done, bfs_sink, mem_wr_en}, 0);
    bfs_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_held_outs", {mem_in_valid, bfs_done, bfs_sink, mem_wr_en, mem_addr_x, mem_addr_y}, 0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_after_outs", {mem_in_valid, bfs_done, bfs_sink, mem_wr_en}, 0);
    chk("rst_board_intact", mem[3*W+2], 2'b01);
    run_shot(2, 3, "rerun_a");
    run_shot(3, 3, "rerun_b");

    clear_board();
    for (int i = 0; i < W; i++) mem[5*W+i] = 2'b01;
    for (int i = 0; i < W; i++) run_shot(i, 5, $sformatf("edge_x%0d", i));
  endtask

  task automatic random_runs(input int n);
    int r;
    for (int k = 0; k < n; k++) begin
      if (k % 4 == 0) begin
        foreach (mem[i]) begin
          r = $urandom_range(0, 9);
          mem[i] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        end
      end
      run_shot($urandom_range(0, W-1), $urandom_range(0, W-1), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b1;
    bfs_start = 1'b0;
    x = 3'd0;
    y = 3'd0;
    clear_board();
    repeat (3) @(negedge clk);
    chk("reset_outs", {mem_in_valid, bfs_done, bfs_sink, mem_wr_en, mem_wr_data, mem_addr_x, mem_addr_y}, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("idle_outs", {mem_in_valid, bfs_done, bfs_sink}, 0);

    lat = 1;
    directed();
    random_runs(24);

    lat = 3;
    directed();
    random_runs(24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
